sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//   Producer side of the SHA-256 round-core interface.
//   - Accepts one 512-bit padded message block.
//   - Streams the expanded message words Wt and round constants Kt, one round per clock.
//   - Frames the 64-round stream with soc/eoc pulses for the compression core.
//   - Sits between block padding/buffering and the compression round datapath.
// PARAMETERS
//   NROUNDS  64  rounds streamed per block; legal range 16..64 (reduced-round values are for debug only)
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   blk_in     in   512  padded block, big-endian: blk_in[511:480] = W0, blk_in[31:0] = W15
//   blk_valid  in   1    blk_in valid
//   blk_ready  out  1    high only in IDLE; block accepted on blk_valid & blk_ready
//   Wt         out  32   message word for the current round
//   Kt         out  32   round constant for the current round
//   soc        out  1    1-cycle pulse marking round 0
//   eoc        out  1    1-cycle pulse on the cycle after the last round
//   round      out  6    current round index t
//   busy       out  1    high in RUN and DONE
// BEHAVIOUR
//   Reset (async, any state, including mid-block):
//     - state = IDLE; round = 0; window cleared.
//     - Outputs: Wt = 0, Kt = 0, soc = 0, eoc = 0, busy = 0, blk_ready = 1.
//     - A block in flight is discarded; no eoc is issued for it.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//     - IDLE: blk_ready = 1. On the edge where blk_valid & blk_ready:
//       load W0..W15 into a 16 x 32-bit window w[0..15]; round <= 0; go to RUN.
//       blk_valid while not in IDLE is ignored (no buffering).
//     - RUN, cycle t (t = 0..NROUNDS-1):
//       Wt = w[0]; Kt = K256[t] (FIPS 180-4 constant table, combinational ROM).
//       soc = (t == 0).
//       Each edge: shift w[i] <= w[i+1], and w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0]
//       (mod 2^32), which is W(t+16).
//       t == NROUNDS-1: go to DONE; otherwise round++.
//     - DONE: exactly one cycle. eoc = 1; Wt = Kt = 0; go to IDLE.
//   Functions:
//     - s0(x) = ROTR7 ^ ROTR18 ^ SHR3
//     - s1(x) = ROTR17 ^ ROTR19 ^ SHR10
//   Timing:
//     - Latency: acceptance edge -> soc asserted in the next cycle.
//     - Acceptance edge to eoc = NROUNDS + 1 cycles.
//     - blk_ready returns high the cycle after eoc.
//     - Block-to-block throughput: NROUNDS + 2 cycles.
//   Output registering:
//     - soc, eoc, blk_ready and busy are decoded directly from registered state.
//     - Wt = w[0] comes from a register.
//     - Kt is ROM-decoded from the registered round value.
//   Arithmetic: all additions truncate to 32 bits; no carry out.
//   round stays at NROUNDS-1 through DONE and clears to 0 on entering IDLE.
// CONFIGURATION
//   SHA_SCHED_ABORT_EN defined:
//     - Adds input port abort (1 bit).
//     - abort high in RUN forces IDLE at the next edge: no eoc, round = 0, outputs return to reset values.
//     - abort in IDLE or DONE has no effect.
//     - If abort and blk_valid are both high in IDLE, the block is accepted.
//   SHA_SCHED_ABORT_EN undefined:
//     - No abort port; a block always completes through eoc.
// TESTING
//   1. Reset: assert rst mid-RUN (t = 20) -> same cycle: soc = eoc = busy = 0, blk_ready = 1, Wt = 0;
//      no eoc afterwards.
//   2. Block "abc" (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018):
//      t0: soc = 1, Wt = 0x61626380, Kt = 0x428a2f98.
//      t15: Wt = 0x00000018.
//      t16: Wt = 0x61626380.
//      t17: Wt = 0x000f0000.
//      t63: Kt = 0xc67178f2.
//      eoc exactly 65 cycles after acceptance.
//   3. Back-to-back: blk_valid held high with two blocks -> second acceptance 66 cycles after the first;
//      blk_valid ignored during RUN; blk_ready low for cycles 1..65 after acceptance.
//   4. Handshake edge cases: blk_valid high for 1 cycle in IDLE -> accepted;
//      blk_valid asserted during DONE -> not accepted until the next IDLE cycle.
//   5. NROUNDS = 16: Wt equals W0..W15 in order; eoc 17 cycles after acceptance.
//   6. SHA_SCHED_ABORT_EN: abort at t = 30 -> IDLE next edge, no eoc, blk_ready = 1;
//      a new block then restarts at t = 0 with soc.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into a framed Wt/Kt round stream.
// Optional feature macro SHA_SCHED_ABORT_EN adds an abort input that cancels a block in RUN.
module sha256_msg_schedule #(
    parameter int NROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk_in,
    input  logic         blk_valid,
`ifdef SHA_SCHED_ABORT_EN
    input  logic         abort,
`endif
    output logic         blk_ready,
    output logic [31:0]  Wt,
    output logic [31:0]  Kt,
    output logic         soc,
    output logic         eoc,
    output logic [5:0]   round,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] LAST = 6'(NROUNDS - 1);

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state, state_nxt;
    logic        load;
    logic        abort_req;
    logic [31:0] w [16];
    logic [31:0] w_next;

`ifdef SHA_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // w[15] receives W(t+16) while w[0] is being presented as W(t)
    assign w_next = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (blk_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort_req)
                    state_nxt = IDLE;
                else if (round == LAST)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            round <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                RUN: begin
                    if (abort_req)
                        round <= '0;
                    else if (round != LAST)
                        round <= round + 6'd1;
                end
                default: round <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                w[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++)
                w[i] <= blk_in[511 - 32*i -: 32];
        end else if (state == RUN) begin
            for (int i = 0; i < 15; i++)
                w[i] <= w[i+1];
            w[15] <= w_next;
        end
    end

    // Outputs are pure decodes of the registered state, round and window
    always_comb begin
        blk_ready = (state == IDLE);
        busy      = (state != IDLE);
        eoc       = (state == DONE);
        soc       = (state == RUN) && (round == 6'd0);
        Wt        = (state == RUN) ? w[0] : 32'h0;
        Kt        = (state == RUN) ? K256[round] : 32'h0;
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: full-round instance plus a 16-round instance.
// Abort scenario is compiled only when SHA_SCHED_ABORT_EN is defined.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] blk_in;
    logic         blk_valid, blk_valid2;
    logic         blk_ready, blk_ready2;
    logic [31:0]  Wt, Wt2, Kt, Kt2;
    logic         soc, soc2, eoc, eoc2, busy, busy2;
    logic [5:0]   round, round2;
`ifdef SHA_SCHED_ABORT_EN
    logic         abort;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int acc_q[$];

    logic [31:0] c_wt [0:79];
    logic [31:0] c_kt [0:79];
    logic        c_soc [0:79];
    logic        c_eoc [0:79];
    logic        c_rdy [0:79];
    logic        c_busy [0:79];
    logic [5:0]  c_rnd [0:79];
    logic [31:0] c2_wt [0:79];
    logic [31:0] c2_kt [0:79];
    logic        c2_soc [0:79];
    logic        c2_eoc [0:79];
    logic        c2_rdy [0:79];
    logic [5:0]  c2_rnd [0:79];

    logic [511:0] blk_abc, blk_a, blk_b, blk_c;

    sha256_msg_schedule #(.NROUNDS(64)) dut (
        .clk(clk), .rst(rst), .blk_in(blk_in), .blk_valid(blk_valid),
`ifdef SHA_SCHED_ABORT_EN
        .abort(abort),
`endif
        .blk_ready(blk_ready), .Wt(Wt), .Kt(Kt), .soc(soc), .eoc(eoc),
        .round(round), .busy(busy)
    );

    sha256_msg_schedule #(.NROUNDS(16)) dut16 (
        .clk(clk), .rst(rst), .blk_in(blk_in), .blk_valid(blk_valid2),
`ifdef SHA_SCHED_ABORT_EN
        .abort(1'b0),
`endif
        .blk_ready(blk_ready2), .Wt(Wt2), .Kt(Kt2), .soc(soc2), .eoc(eoc2),
        .round(round2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && blk_valid && blk_ready)
            acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic send(input logic [511:0] b, input bit second);
        @(negedge clk);
        blk_in = b;
        if (second) blk_valid2 = 1'b1;
        else        blk_valid  = 1'b1;
        @(posedge clk);
    endtask

    // Sample index k is the k-th cycle after the acceptance edge.
    task automatic capture(input int n, input bit hold, input int swap_at, input logic [511:0] swap_val);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            c_wt[k] = Wt;   c_kt[k] = Kt;   c_soc[k] = soc;   c_eoc[k] = eoc;
            c_rdy[k] = blk_ready; c_busy[k] = busy; c_rnd[k] = round;
            c2_wt[k] = Wt2; c2_kt[k] = Kt2; c2_soc[k] = soc2; c2_eoc[k] = eoc2;
            c2_rdy[k] = blk_ready2; c2_rnd[k] = round2;
            if (!hold && k == 1) begin
                blk_valid  = 1'b0;
                blk_valid2 = 1'b0;
            end
            if (k == swap_at) blk_in = swap_val;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || busy2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (busy || busy2) begin
            mismatched++;
            $display("FAIL drain_timeout: busy=%b busy2=%b, required both 0", busy, busy2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n_eoc = 0;
        rst = 1'b1;
        #1;
        compared++;
        if ({soc, eoc, busy, blk_ready} !== 4'b0001) begin
            mismatched++;
            $display("FAIL reset_ctrl: soc/eoc/busy/rdy=%b, required 0001", {soc, eoc, busy, blk_ready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (Wt !== 32'h0 || Kt !== 32'h0 || round !== 6'd0) begin
            mismatched++;
            $display("FAIL reset_data: Wt=%h Kt=%h round=%0d, required 0/0/0", Wt, Kt, round);
        end
        send(blk_abc, 1'b0);
        capture(21, 1'b0, 0, '0);
        compared++;
        if (c_rnd[21] !== 6'd20 || c_busy[21] !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_pre_round: round=%0d busy=%b, required 20/1", c_rnd[21], c_busy[21]);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({soc, eoc, busy, blk_ready} !== 4'b0001) begin
            mismatched++;
            $display("FAIL reset_mid_ctrl: soc/eoc/busy/rdy=%b, required 0001", {soc, eoc, busy, blk_ready});
        end
        compared++;
        if (Wt !== 32'h0 || Kt !== 32'h0 || round !== 6'd0) begin
            mismatched++;
            $display("FAIL reset_mid_data: Wt=%h Kt=%h round=%0d, required 0/0/0", Wt, Kt, round);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (eoc) n_eoc++;
        end
        compared++;
        if (n_eoc != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_no_eoc: eoc count=%0d busy=%b, required 0/0", n_eoc, busy);
        end
    endtask

    task automatic test_abc();
        int n_soc = 0, n_eoc = 0, n_busy = 0;
        send(blk_abc, 1'b0);
        capture(70, 1'b0, 0, '0);
        compared++;
        if (c_soc[1] !== 1'b1 || c_wt[1] !== 32'h61626380 || c_kt[1] !== 32'h428a2f98) begin
            mismatched++;
            $display("FAIL abc_t0: soc=%b Wt=%h Kt=%h, required 1/61626380/428a2f98", c_soc[1], c_wt[1], c_kt[1]);
        end
        compared++;
        if (c_kt[2] !== 32'h71374491) begin
            mismatched++;
            $display("FAIL abc_k1: got %h, required 71374491", c_kt[2]);
        end
        compared++;
        if (c_wt[16] !== 32'h00000018) begin
            mismatched++;
            $display("FAIL abc_w15: got %h, required 00000018", c_wt[16]);
        end
        compared++;
        if (c_wt[17] !== 32'h61626380) begin
            mismatched++;
            $display("FAIL abc_w16: got %h, required 61626380", c_wt[17]);
        end
        compared++;
        if (c_wt[18] !== 32'h000f0000) begin
            mismatched++;
            $display("FAIL abc_w17: got %h, required 000f0000", c_wt[18]);
        end
        compared++;
        if (c_kt[33] !== 32'h27b70a85) begin
            mismatched++;
            $display("FAIL abc_k32: got %h, required 27b70a85", c_kt[33]);
        end
        compared++;
        if (c_kt[64] !== 32'hc67178f2 || c_rnd[64] !== 6'd63) begin
            mismatched++;
            $display("FAIL abc_t63: Kt=%h round=%0d, required c67178f2/63", c_kt[64], c_rnd[64]);
        end
        compared++;
        if (c_eoc[64] !== 1'b0 || c_eoc[65] !== 1'b1) begin
            mismatched++;
            $display("FAIL abc_eoc_time: eoc@64=%b eoc@65=%b, required 0/1", c_eoc[64], c_eoc[65]);
        end
        compared++;
        if (c_wt[65] !== 32'h0 || c_kt[65] !== 32'h0 || c_rnd[65] !== 6'd63) begin
            mismatched++;
            $display("FAIL abc_done: Wt=%h Kt=%h round=%0d, required 0/0/63", c_wt[65], c_kt[65], c_rnd[65]);
        end
        compared++;
        if (c_rdy[65] !== 1'b0 || c_rdy[66] !== 1'b1 || c_rnd[66] !== 6'd0) begin
            mismatched++;
            $display("FAIL abc_ready_back: rdy@65=%b rdy@66=%b round@66=%0d, required 0/1/0", c_rdy[65], c_rdy[66], c_rnd[66]);
        end
        for (int k = 1; k <= 70; k++) begin
            if (c_soc[k]) n_soc++;
            if (c_eoc[k]) n_eoc++;
            if (c_busy[k]) n_busy++;
        end
        compared++;
        if (n_soc != 1 || n_eoc != 1 || n_busy != 65) begin
            mismatched++;
            $display("FAIL abc_pulse_counts: soc=%0d eoc=%0d busy=%0d, required 1/1/65", n_soc, n_eoc, n_busy);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int low_cnt = 0;
        acc_q.delete();
        send(blk_a, 1'b0);
        capture(70, 1'b1, 3, blk_b);
        blk_valid = 1'b0;
        compared++;
        if (acc_q.size() != 2) begin
            mismatched++;
            $display("FAIL b2b_accept_count: got %0d, required 2", acc_q.size());
        end else begin
            compared++;
            if (acc_q[1] - acc_q[0] != 66) begin
                mismatched++;
                $display("FAIL b2b_spacing: got %0d, required 66", acc_q[1] - acc_q[0]);
            end
        end
        for (int k = 1; k <= 65; k++)
            if (c_rdy[k] === 1'b0) low_cnt++;
        compared++;
        if (low_cnt != 65 || c_rdy[66] !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_ready: low cycles=%0d rdy@66=%b, required 65/1", low_cnt, c_rdy[66]);
        end
        compared++;
        if (c_wt[6] !== 32'ha0a00005) begin
            mismatched++;
            $display("FAIL b2b_no_reload: Wt@t5=%h, required a0a00005", c_wt[6]);
        end
        compared++;
        if (c_soc[67] !== 1'b1 || c_wt[67] !== 32'hb0b00000) begin
            mismatched++;
            $display("FAIL b2b_second: soc=%b Wt=%h, required 1/b0b00000", c_soc[67], c_wt[67]);
        end
        drain();
    endtask

    task automatic test_handshake();
        acc_q.delete();
        send(blk_a, 1'b0);
        capture(65, 1'b0, 0, '0);
        compared++;
        if (c_soc[1] !== 1'b1 || c_eoc[65] !== 1'b1) begin
            mismatched++;
            $display("FAIL hs_pulse_accept: soc@1=%b eoc@65=%b, required 1/1", c_soc[1], c_eoc[65]);
        end
        blk_valid = 1'b1;
        @(negedge clk);
        compared++;
        if (blk_ready !== 1'b1 || soc !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL hs_done_ignored: rdy=%b soc=%b busy=%b, required 1/0/0", blk_ready, soc, busy);
        end
        @(negedge clk);
        blk_valid = 1'b0;
        compared++;
        if (soc !== 1'b1 || Wt !== 32'ha0a00000) begin
            mismatched++;
            $display("FAIL hs_idle_accept: soc=%b Wt=%h, required 1/a0a00000", soc, Wt);
        end
        compared++;
        if (acc_q.size() != 2 || acc_q[acc_q.size()-1] - acc_q[0] != 66) begin
            mismatched++;
            $display("FAIL hs_spacing: accepts=%0d, required 2 spaced by 66", acc_q.size());
        end
        drain();
    endtask

    task automatic test_short_rounds();
        int bad = 0;
        send(blk_c, 1'b1);
        capture(20, 1'b0, 0, '0);
        compared++;
        if (c_busy[1] !== 1'b0 || c2_soc[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL nr16_start: busy64=%b soc16=%b, required 0/1", c_busy[1], c2_soc[1]);
        end
        for (int k = 1; k <= 16; k++) begin
            compared++;
            if (c2_wt[k] !== (32'hc0de0000 | 32'(k - 1))) begin
                mismatched++;
                bad++;
                $display("FAIL nr16_w%0d: got %h, required %h", k - 1, c2_wt[k], 32'hc0de0000 | 32'(k - 1));
            end
        end
        compared++;
        if (c2_kt[16] !== 32'hc19bf174 || c2_rnd[16] !== 6'd15) begin
            mismatched++;
            $display("FAIL nr16_t15: Kt=%h round=%0d, required c19bf174/15", c2_kt[16], c2_rnd[16]);
        end
        compared++;
        if (c2_eoc[16] !== 1'b0 || c2_eoc[17] !== 1'b1 || c2_rdy[18] !== 1'b1) begin
            mismatched++;
            $display("FAIL nr16_eoc: eoc@16=%b eoc@17=%b rdy@18=%b, required 0/1/1", c2_eoc[16], c2_eoc[17], c2_rdy[18]);
        end
        drain();
    endtask

`ifdef SHA_SCHED_ABORT_EN
    task automatic test_abort();
        int n_eoc = 0;
        send(blk_abc, 1'b0);
        capture(31, 1'b0, 0, '0);
        compared++;
        if (c_rnd[31] !== 6'd30) begin
            mismatched++;
            $display("FAIL abort_pre_round: got %0d, required 30", c_rnd[31]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if ({soc, eoc, busy, blk_ready} !== 4'b0001 || round !== 6'd0 || Wt !== 32'h0 || Kt !== 32'h0) begin
            mismatched++;
            $display("FAIL abort_idle: soc/eoc/busy/rdy=%b round=%0d Wt=%h Kt=%h, required 0001/0/0/0",
                     {soc, eoc, busy, blk_ready}, round, Wt, Kt);
        end
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (eoc) n_eoc++;
        end
        compared++;
        if (n_eoc != 0) begin
            mismatched++;
            $display("FAIL abort_no_eoc: eoc count=%0d, required 0", n_eoc);
        end
        send(blk_abc, 1'b0);
        capture(3, 1'b0, 0, '0);
        compared++;
        if (c_soc[1] !== 1'b1 || c_rnd[1] !== 6'd0 || c_wt[1] !== 32'h61626380) begin
            mismatched++;
            $display("FAIL abort_restart: soc=%b round=%0d Wt=%h, required 1/0/61626380", c_soc[1], c_rnd[1], c_wt[1]);
        end
        drain();
    endtask
`endif

    initial begin
        rst        = 1'b1;
        blk_valid  = 1'b0;
        blk_valid2 = 1'b0;
        blk_in     = '0;
`ifdef SHA_SCHED_ABORT_EN
        abort      = 1'b0;
`endif
        blk_abc = {32'h61626380, 448'h0, 32'h00000018};
        for (int i = 0; i < 16; i++) begin
            blk_a[511 - 32*i -: 32] = 32'ha0a00000 | 32'(i);
            blk_b[511 - 32*i -: 32] = 32'hb0b00000 | 32'(i);
            blk_c[511 - 32*i -: 32] = 32'hc0de0000 | 32'(i);
        end
        test_reset();
        test_abc();
        test_back_to_back();
        test_handshake();
        test_short_rounds();
`ifdef SHA_SCHED_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
